// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch: prescaled tick counting, start/stop, clear, optional lap freeze.
// Optional lap function compiled in with `define BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int TICKS_PER_COUNT = 100
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count_bcd,
  output logic [15:0] display_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [11:0] PRE_MAX = 12'(TICKS_PER_COUNT - 1);

  state_t      state_q, state_d;
  logic [11:0] pre_q, pre_d;
  logic [15:0] count_d;
  logic [15:0] display_d;
  logic [16:0] inc;
  logic        wrap_d;

  // Returns {carry_out, incremented value}; carry_out is set only for 9999 -> 0000.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = STOPPED;
    end else if (start_stop) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end
  end

  // Tick qualification uses the pre-edge state so a coincident start_stop cannot affect it.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_bcd;
    wrap_d  = 1'b0;
    inc     = bcd_inc(count_bcd);
    if (clear) begin
      pre_d   = 12'd0;
      count_d = 16'h0000;
    end else if (state_q == RUNNING && tick) begin
      if (pre_q == PRE_MAX) begin
        pre_d   = 12'd0;
        count_d = inc[15:0];
        wrap_d  = inc[16];
      end else begin
        pre_d = pre_q + 12'd1;
      end
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic        lap_d;
  logic [15:0] hold_q, hold_d;

  // The hold register captures the post-edge count so the frozen value matches what was shown.
  always_comb begin
    lap_d  = lap_active;
    hold_d = hold_q;
    if (clear) begin
      lap_d = 1'b0;
    end else if (lap) begin
      if (lap_active) begin
        lap_d = 1'b0;
      end else begin
        lap_d  = 1'b1;
        hold_d = count_d;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      hold_q     <= 16'h0000;
      lap_active <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      lap_active <= lap_d;
    end
  end

  assign display_d = lap_d ? hold_d : count_d;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign display_d  = count_d;
`endif

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= STOPPED;
      pre_q       <= 12'd0;
      count_bcd   <= 16'h0000;
      display_bcd <= 16'h0000;
      wrap        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      count_bcd   <= count_d;
      display_bcd <= display_d;
      wrap        <= wrap_d;
    end
  end

  assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch with TICKS_PER_COUNT = 4: vector table,
// reference-model scoreboard, and directed sequences for rollover, lap and clear/reset.
module tb_bcd_stopwatch;
  localparam int T = 4;
`ifdef BCD_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] count_bcd, display_bcd;
  logic        running, lap_active, wrap;

  always #5 clk = ~clk;

  bcd_stopwatch #(.TICKS_PER_COUNT(T)) dut (
    .clkin(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .count_bcd(count_bcd), .display_bcd(display_bcd),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];

  // Reference model: plain integer count converted to BCD for comparison.
  int m_cnt = 0, m_pre = 0, m_hold = 0;
  bit m_run = 1'b0, m_lap = 1'b0, m_wrap = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit t, input bit ss, input bit clr, input bit lp, input bit rst);
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_hold = 0; m_run = 1'b0; m_lap = 1'b0; m_wrap = 1'b0;
    end else if (clr) begin
      m_cnt = 0; m_pre = 0; m_run = 1'b0; m_lap = 1'b0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (m_run && t) begin
        if (m_pre == T - 1) begin
          m_pre  = 0;
          m_cnt  = (m_cnt + 1) % 10000;
          m_wrap = (m_cnt == 0);
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (ss) m_run = !m_run;
      if (LAP_EN && lp) begin
        if (!m_lap) begin
          m_hold = m_cnt;
          m_lap  = 1'b1;
        end else begin
          m_lap = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit t, input bit ss, input bit clr, input bit lp, input bit rst);
    logic [34:0] got, exp;
    tick = t; start_stop = ss; clear = clr; lap = lp; reset = rst;
    model_step(t, ss, clr, lp, rst);
    exp_q.push_back({to_bcd(m_cnt), to_bcd(m_lap ? m_hold : m_cnt), m_run, m_lap, m_wrap});
    @(posedge clk);
    #1;
    got = {count_bcd, display_bcd, running, lap_active, wrap};
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL scoreboard @%0t got cnt=%h disp=%h run=%b lap=%b wrap=%b, exp cnt=%h disp=%h run=%b lap=%b wrap=%b",
               $time, got[34:19], got[18:3], got[2], got[1], got[0],
               exp[34:19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          t, ss, clr, lp, rst;
    logic [15:0] cnt;
    bit          run;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input bit t, input bit ss, input bit clr, input bit lp, input bit rst,
                     input logic [15:0] cnt, input bit run);
    vecs[nv] = '{t, ss, clr, lp, rst, cnt, run};
    nv++;
  endtask

  initial begin
    // Reset, start, 8 ticks -> 0x0002.
    add(0, 0, 0, 0, 1, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0002, 1);
    // Clear, start, 6 ticks, stop, 10 ignored ticks, start, 2 ticks -> 0x0002.
    add(0, 0, 1, 0, 0, 16'h0000, 0);
    add(0, 1, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(0, 1, 0, 0, 0, 16'h0001, 0);
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 16'h0001, 0);
    add(0, 1, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0001, 1);
    add(1, 0, 0, 0, 0, 16'h0002, 1);
    // tick+start_stop from RUNNING counts (pre 1), from STOPPED is ignored; 3 ticks -> 0x0003.
    add(1, 1, 0, 0, 0, 16'h0002, 0);
    add(1, 1, 0, 0, 0, 16'h0002, 1);
    add(1, 0, 0, 0, 0, 16'h0002, 1);
    add(1, 0, 0, 0, 0, 16'h0002, 1);
    add(1, 0, 0, 0, 0, 16'h0003, 1);

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].t, vecs[i].ss, vecs[i].clr, vecs[i].lp, vecs[i].rst);
      check("table_count", count_bcd, vecs[i].cnt);
      check("table_running", {15'd0, running}, {15'd0, vecs[i].run});
      check("table_wrap", {15'd0, wrap}, 16'h0000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit rt, rss, rclr, rlp;
      rt   = bit'($urandom_range(0, 1));
      rss  = ($urandom_range(0, 15) == 0);
      rclr = ($urandom_range(0, 63) == 0);
      rlp  = ($urandom_range(0, 11) == 0);
      step(rt, rss, rclr, rlp, 1'b0);
    end

    // Digit carry and 9999 -> 0000 rollover.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    tick_n(396);
    check("preload_99", count_bcd, 16'h0099);
    tick_n(4);
    check("carry_100", count_bcd, 16'h0100);
    tick_n(39596);
    check("preload_9999", count_bcd, 16'h9999);
    tick_n(3);
    check("no_wrap_early", {15'd0, wrap}, 16'h0000);
    tick_n(1);
    check("rollover_count", count_bcd, 16'h0000);
    check("wrap_pulse", {15'd0, wrap}, 16'h0001);
    step(0, 0, 0, 0, 0);
    check("wrap_one_cycle", {15'd0, wrap}, 16'h0000);

    // Lap freeze at 0x0003, count keeps going, release shows live count.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    tick_n(12);
    check("lap_pre_count", count_bcd, 16'h0003);
    step(0, 0, 0, 1, 0);
    check("lap_active_set", {15'd0, lap_active}, {15'd0, LAP_EN});
    tick_n(8);
    check("lap_live_count", count_bcd, 16'h0005);
    check("lap_frozen_disp", display_bcd, LAP_EN ? 16'h0003 : 16'h0005);
    step(0, 0, 0, 1, 0);
    check("lap_release_disp", display_bcd, 16'h0005);
    check("lap_release_flag", {15'd0, lap_active}, 16'h0000);

    // Clear beats tick/start_stop/lap at 0x0042 while frozen.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    tick_n(168);
    check("pre_clear_count", count_bcd, 16'h0042);
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    check("clear_count", count_bcd, 16'h0000);
    check("clear_running", {15'd0, running}, 16'h0000);
    check("clear_lap", {15'd0, lap_active}, 16'h0000);
    check("clear_disp", display_bcd, 16'h0000);

    // Reset beats clear and everything else, mid-count and mid-lap.
    step(0, 1, 0, 0, 0);
    tick_n(7);
    step(0, 0, 0, 1, 0);
    tick_n(5);
    step(1, 1, 1, 1, 1);
    check("reset_count", count_bcd, 16'h0000);
    check("reset_disp", display_bcd, 16'h0000);
    check("reset_running", {15'd0, running}, 16'h0000);
    check("reset_lap", {15'd0, lap_active}, 16'h0000);
    check("reset_wrap", {15'd0, wrap}, 16'h0000);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_stopped_idle", count_bcd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
